// File: rtl/sim_stim_pkg.sv
// Shared state encodings and sizing helper for the bench stimulus controller.
package sim_stim_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_TOUT = 2'd3
  } state_e;

  // A one-cycle hold still needs a 1-bit counter.
  function automatic int hold_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sched.sv
// One interrupt channel: next-fire compare, armed bit, pulse/level line, overflow flag.
// Output is registered; fires are evaluated only while run_i is high.
module irq_sched #(
  parameter int               CNT_W  = 32,
  parameter logic [CNT_W-1:0] START  = '0,
  parameter logic [CNT_W-1:0] PERIOD = '0,
  parameter bit               LEVEL  = 1'b0,
  parameter bit               EN     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic             flush_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] next_q, next_d;
  logic             armed_q, armed_d;
  logic             irq_q, irq_d;
  logic             ovf_q, ovf_d;
  logic             fire;

  always_comb begin
    fire    = run_i && armed_q && (cnt_i == next_q);
    next_d  = next_q;
    armed_d = armed_q;
    irq_d   = irq_q;
    ovf_d   = ovf_q;

    if (fire) begin
      if (PERIOD != '0) next_d = next_q + PERIOD;
      else              armed_d = 1'b0;
    end

    // A fire in the same cycle as an ack takes priority over the clear.
    if (flush_i) begin
      irq_d = 1'b0;
    end else if (LEVEL) begin
      if (fire) begin
        irq_d = 1'b1;
        if (irq_q) ovf_d = 1'b1;
      end else if (ack_i) begin
        irq_d = 1'b0;
      end
    end else begin
      irq_d = fire;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_q  <= START;
      armed_q <= EN;
      irq_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      next_q  <= next_d;
      armed_q <= armed_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
    end
  end

  assign irq_o = irq_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/sim_stim_ctrl.sv
// CPU bench sequencer: reset hold, run-cycle counter, scheduled IRQs, halt/watchdog stop.
// All outputs registered, one cycle after the deciding edge.
module sim_stim_ctrl
  import sim_stim_pkg::*;
#(
  parameter int                         RST_CYCLES = 4,
  parameter int                         NUM_IRQ    = 6,
  parameter int                         CNT_W      = 32,
  parameter int                         TIMEOUT    = 100000,
  parameter logic [NUM_IRQ*CNT_W-1:0]   IRQ_START  = '0,
  parameter logic [NUM_IRQ*CNT_W-1:0]   IRQ_PERIOD = '0,
  parameter logic [NUM_IRQ-1:0]         IRQ_LEVEL  = '0,
  parameter logic [NUM_IRQ-1:0]         IRQ_EN     = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic [NUM_IRQ-1:0] irq_ack,
  output logic               cpu_reset,
  output logic [NUM_IRQ-1:0] hwint,
  output logic [NUM_IRQ-1:0] irq_ovf,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [1:0]         state,
  output logic               done,
  output logic               timeout
);

  localparam int               HOLD_W    = hold_width(RST_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TIMEOUT - 1);

  state_e            state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              cpu_reset_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              done_q;
  logic              tout_q;

  logic in_run, term, ch_run, ch_flush;

  // Channels see no fire on the terminating edge so the lines drop with the state change.
  assign in_run   = (state_q == ST_RUN);
  assign term     = in_run && (halt || (cnt_q == LAST_CNT));
  assign ch_run   = in_run && !term;
  assign ch_flush = term || (state_q == ST_DONE) || (state_q == ST_TOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HOLD;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          hold_q <= hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (cnt_q == LAST_CNT) begin
            state_q <= ST_TOUT;
            tout_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_ch
    irq_sched #(
      .CNT_W  (CNT_W),
      .START  (IRQ_START[i*CNT_W +: CNT_W]),
      .PERIOD (IRQ_PERIOD[i*CNT_W +: CNT_W]),
      .LEVEL  (IRQ_LEVEL[i]),
      .EN     (IRQ_EN[i])
    ) u_sched (
      .clk     (clk),
      .reset   (reset),
      .run_i   (ch_run),
      .flush_i (ch_flush),
      .cnt_i   (cnt_q),
      .ack_i   (irq_ack[i]),
      .irq_o   (hwint[i]),
      .ovf_o   (irq_ovf[i])
    );
  end

  assign cpu_reset = cpu_reset_q;
  assign cycle_cnt = cnt_q;
  assign state     = state_q;
  assign done      = done_q;
  assign timeout   = tout_q;

endmodule

// File: tb/tb_sim_stim_ctrl.sv
// Directed bench: dut_a covers hold, pulse/level IRQs, mid-run reset and watchdog; dut_b covers halt/timeout tie, one-shots, RST_CYCLES=1.
module tb_sim_stim_ctrl;
  import sim_stim_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut_a: 6 channels, 32-bit counter, watchdog at 50
  logic        rst_a, halt_a, cpurst_a, done_a, tout_a;
  logic [5:0]  ack_a, hwint_a, ovf_a;
  logic [31:0] cnt_a;
  logic [1:0]  st_a;

  sim_stim_ctrl #(
    .RST_CYCLES (4),
    .NUM_IRQ    (6),
    .CNT_W      (32),
    .TIMEOUT    (50),
    .IRQ_START  ({128'd0, 32'd3, 32'd10}),
    .IRQ_PERIOD ({128'd0, 32'd4, 32'd5}),
    .IRQ_LEVEL  (6'b000010),
    .IRQ_EN     (6'b000011)
  ) dut_a (
    .clk (clk), .reset (rst_a), .halt (halt_a), .irq_ack (ack_a),
    .cpu_reset (cpurst_a), .hwint (hwint_a), .irq_ovf (ovf_a),
    .cycle_cnt (cnt_a), .state (st_a), .done (done_a), .timeout (tout_a)
  );

  // dut_b: 3 channels, 16-bit counter, watchdog at 20, single hold cycle
  logic        rst_b, halt_b, cpurst_b, done_b, tout_b;
  logic [2:0]  ack_b, hwint_b, ovf_b;
  logic [15:0] cnt_b;
  logic [1:0]  st_b;

  sim_stim_ctrl #(
    .RST_CYCLES (1),
    .NUM_IRQ    (3),
    .CNT_W      (16),
    .TIMEOUT    (20),
    .IRQ_START  ({16'd5, 16'd17, 16'd2}),
    .IRQ_PERIOD ({16'd0, 16'd0, 16'd3}),
    .IRQ_LEVEL  (3'b010),
    .IRQ_EN     (3'b110)
  ) dut_b (
    .clk (clk), .reset (rst_b), .halt (halt_b), .irq_ack (ack_b),
    .cpu_reset (cpurst_b), .hwint (hwint_b), .irq_ovf (ovf_b),
    .cycle_cnt (cnt_b), .state (st_b), .done (done_b), .timeout (tout_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ch0 pulse S=10 P=5; ch1 level S=3 P=4, acked at 10 and at 15 (coincides with a fire)
  function automatic logic [5:0] exp_hwint_a(input int c);
    logic p0, l1;
    p0 = (c >= 11) && (((c - 11) % 5) == 0);
    l1 = ((c >= 4) && (c <= 10)) || (c >= 12);
    return {4'b0000, l1, p0};
  endfunction

  task automatic rst_check_a(input string tag);
    chk({tag, "_state"}, st_a, ST_HOLD);
    chk({tag, "_cpurst"}, cpurst_a, 1'b1);
    chk({tag, "_hwint"}, hwint_a, 6'd0);
    chk({tag, "_ovf"}, ovf_a, 6'd0);
    chk({tag, "_cnt"}, cnt_a, 32'd0);
    chk({tag, "_done"}, done_a, 1'b0);
    chk({tag, "_tout"}, tout_a, 1'b0);
  endtask

  task automatic hold_a();
    rst_a = 1'b1;
    repeat (3) step();
    rst_check_a("a_rst");
    rst_a = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("a_hold_cpurst", cpurst_a, (k < 4) ? 1'b1 : 1'b0);
      chk("a_hold_state", st_a, (k < 4) ? ST_HOLD : ST_RUN);
    end
    chk("a_run_cnt0", cnt_a, 32'd0);
  endtask

  task automatic run_a(input bit abort, output int c_end);
    int c;
    int guard;
    c = 0;
    guard = 0;
    while (st_a == ST_RUN && guard < 200) begin
      chk("a_cnt", cnt_a, c);
      chk("a_hwint", hwint_a, exp_hwint_a(c));
      chk("a_ovf", ovf_a, (c >= 8) ? 6'b000010 : 6'b000000);
      ack_a = (c == 10 || c == 15) ? 6'b000010 : 6'b000000;
      if (abort && c == 30) rst_a = 1'b1;
      step();
      guard++;
      if (abort && c == 30) break;
      c++;
    end
    chk("a_run_bound", guard < 200, 1'b1);
    ack_a = '0;
    c_end = c;
  endtask

  initial begin
    int c_end;
    int c;
    int guard;
    rst_a = 1'b1; halt_a = 1'b0; ack_a = '0;
    rst_b = 1'b1; halt_b = 1'b1; ack_b = '0;

    // dut_a: first pass aborted by reset at cnt 30 with ch1 pending
    hold_a();
    run_a(1'b1, c_end);
    chk("a_abort_at", c_end, 30);
    rst_check_a("a_abort");

    // replay, then run into the watchdog
    hold_a();
    run_a(1'b0, c_end);
    chk("a_tout_at", c_end, 50);
    chk("a_tout_state", st_a, ST_TOUT);
    chk("a_tout_flag", tout_a, 1'b1);
    chk("a_tout_done", done_a, 1'b0);
    chk("a_tout_cnt", cnt_a, 32'd49);
    chk("a_tout_hwint", hwint_a, 6'd0);
    chk("a_tout_ovf", ovf_a, 6'b000010);
    halt_a = 1'b1;
    repeat (2) step();
    chk("a_post_halt_done", done_a, 1'b0);
    chk("a_post_halt_state", st_a, ST_TOUT);
    chk("a_post_halt_cnt", cnt_a, 32'd49);
    halt_a = 1'b0;

    // dut_b: halt held through reset and the single hold cycle is ignored
    step();
    chk("b_rst_state", st_b, ST_HOLD);
    chk("b_rst_cpurst", cpurst_b, 1'b1);
    rst_b = 1'b0;
    step();
    chk("b_hold_state", st_b, ST_RUN);
    chk("b_hold_cpurst", cpurst_b, 1'b0);
    chk("b_hold_done", done_b, 1'b0);
    halt_b = 1'b0;
    c = 0;
    guard = 0;
    while (st_b == ST_RUN && guard < 100) begin
      chk("b_cnt", cnt_b, c);
      chk("b_hwint", hwint_b, {(c == 6), (c >= 18), 1'b0});
      if (c == 19) halt_b = 1'b1;
      step();
      guard++;
      c++;
    end
    chk("b_run_bound", guard < 100, 1'b1);
    chk("b_stop_at", c, 20);
    chk("b_done_state", st_b, ST_DONE);
    chk("b_done_flag", done_b, 1'b1);
    chk("b_done_tout", tout_b, 1'b0);
    chk("b_done_cnt", cnt_b, 16'd19);
    chk("b_done_hwint", hwint_b, 3'd0);
    chk("b_done_ovf", ovf_b, 3'd0);
    halt_b = 1'b0;
    ack_b = 3'b111;
    repeat (2) step();
    chk("b_term_state", st_b, ST_DONE);
    chk("b_term_cnt", cnt_b, 16'd19);
    chk("b_term_tout", tout_b, 1'b0);
    chk("b_term_cpurst", cpurst_b, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
